// File: rtl/controlador_requisicoes_caminho.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : controlador_requisicoes_caminho                              |
// | Description : Request front-end and result streamer for the path-search   |
// |               core. Queues (fonte, destino) requests in a small FIFO,      |
// |               launches the core one request at a time, buffers the path    |
// |               nodes it returns and streams them out with valid/ready/last. |
// |               A cycle timer aborts hung searches and reports an error.     |
// | Ports       : clk, rst_n (sync, active-low)                                |
// |               req_*     : request handshake (valid/ready, fonte, destino)  |
// |               nucleo_*  : core control (iniciar, abortar, fonte, destino)  |
// |                           and core results (dado_valido, dado, pronto)     |
// |               cam_*     : path stream (valid/ready, addr, ultimo, erro)    |
// |               ocupado_out : busy indication                                |
// | Option      : CONTROLADOR_ESTATISTICAS_EN adds stat_concluidos_out and     |
// |               stat_timeouts_out (16-bit saturating counters).              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module controlador_requisicoes_caminho #(
  parameter int ADDR_WIDTH     = 10,
  parameter int FILA_DEPTH     = 4,
  parameter int MAX_CAMINHO    = 64,
  parameter int TIMEOUT_CICLOS = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [ADDR_WIDTH-1:0] req_fonte_in,
  input  logic [ADDR_WIDTH-1:0] req_destino_in,
  output logic                  nucleo_iniciar_out,
  output logic                  nucleo_abortar_out,
  output logic [ADDR_WIDTH-1:0] nucleo_fonte_out,
  output logic [ADDR_WIDTH-1:0] nucleo_destino_out,
  input  logic                  nucleo_dado_valido_in,
  input  logic [ADDR_WIDTH-1:0] nucleo_dado_in,
  input  logic                  nucleo_pronto_in,
  output logic                  cam_valid_out,
  input  logic                  cam_ready_in,
  output logic [ADDR_WIDTH-1:0] cam_addr_out,
  output logic                  cam_ultimo_out,
  output logic                  cam_erro_out,
`ifdef CONTROLADOR_ESTATISTICAS_EN
  output logic [15:0]           stat_concluidos_out,
  output logic [15:0]           stat_timeouts_out,
`endif
  output logic                  ocupado_out
);

  localparam int PTR_W  = $clog2(FILA_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(MAX_CAMINHO) + 1;
  localparam int IDX_W  = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CICLOS);

  localparam logic [FCNT_W-1:0] C_FILA_CHEIA = FCNT_W'(FILA_DEPTH);
  localparam logic [CNT_W-1:0]  C_CAM_MAX    = CNT_W'(MAX_CAMINHO);
  localparam logic [TMR_W-1:0]  C_TMR_LIMITE = TMR_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIAR  = 3'd1,
    BUSCANDO = 3'd2,
    ENVIANDO = 3'd3,
    ERRO     = 3'd4
  } estado_t;

  estado_t r_estado, w_prox_estado;

  // Request FIFO
  logic [ADDR_WIDTH-1:0] r_fila_fonte   [FILA_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fila_destino [FILA_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [FCNT_W-1:0]     r_fila_cnt;
  logic                  w_push, w_pop;

  // Path buffer and search bookkeeping
  logic [ADDR_WIDTH-1:0] r_buf [MAX_CAMINHO];
  logic [CNT_W-1:0]      r_count, r_rd;
  logic [TMR_W-1:0]      r_timer;
  logic                  r_ovf;
  logic [ADDR_WIDTH-1:0] r_fonte, r_destino;

  logic w_grava, w_ovf_set, w_hs;

  // Full flag comes only from the registered count, so ready never
  // depends combinationally on any input.
  assign req_ready_out      = (r_fila_cnt != C_FILA_CHEIA);
  assign w_push             = req_valid_in & req_ready_out;
  assign w_pop              = (r_estado == OCIOSO) & (r_fila_cnt != '0);
  assign nucleo_fonte_out   = r_fonte;
  assign nucleo_destino_out = r_destino;
  assign ocupado_out        = (r_estado != OCIOSO) | (r_fila_cnt != '0);
  assign w_hs               = cam_valid_out & cam_ready_in;

  always_comb begin
    w_prox_estado      = r_estado;
    nucleo_iniciar_out = 1'b0;
    nucleo_abortar_out = 1'b0;
    cam_valid_out      = 1'b0;
    cam_addr_out       = '0;
    cam_ultimo_out     = 1'b0;
    cam_erro_out       = 1'b0;
    w_grava            = 1'b0;
    w_ovf_set          = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (r_fila_cnt != '0) w_prox_estado = INICIAR;
      end
      INICIAR: begin
        nucleo_iniciar_out = 1'b1;
        w_prox_estado      = BUSCANDO;
      end
      BUSCANDO: begin
        if (nucleo_dado_valido_in) begin
          if (r_count < C_CAM_MAX) w_grava   = 1'b1;
          else                     w_ovf_set = 1'b1;
        end
        // A beat arriving with pronto is stored this cycle, so it counts
        // towards a non-empty path.
        if (nucleo_pronto_in) begin
          w_prox_estado = ((r_count != '0) | nucleo_dado_valido_in) ? ENVIANDO : ERRO;
        end else if (r_timer == C_TMR_LIMITE) begin
          nucleo_abortar_out = 1'b1;
          w_prox_estado      = ERRO;
        end
      end
      ENVIANDO: begin
        cam_valid_out  = 1'b1;
        cam_addr_out   = r_buf[r_rd[IDX_W-1:0]];
        cam_ultimo_out = (r_rd == (r_count - CNT_W'(1)));
        cam_erro_out   = r_ovf & cam_ultimo_out;
        if (cam_ready_in & cam_ultimo_out) w_prox_estado = OCIOSO;
      end
      ERRO: begin
        cam_valid_out  = 1'b1;
        cam_ultimo_out = 1'b1;
        cam_erro_out   = 1'b1;
        if (cam_ready_in) w_prox_estado = OCIOSO;
      end
      default: w_prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado   <= OCIOSO;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fila_cnt <= '0;
      r_count    <= '0;
      r_rd       <= '0;
      r_timer    <= '0;
      r_ovf      <= 1'b0;
      r_fonte    <= '0;
      r_destino  <= '0;
    end else begin
      r_estado <= w_prox_estado;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_fonte   <= r_fila_fonte[r_rd_ptr];
        r_destino <= r_fila_destino[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_fila_cnt <= r_fila_cnt + FCNT_W'(1);
        2'b01:   r_fila_cnt <= r_fila_cnt - FCNT_W'(1);
        default: r_fila_cnt <= r_fila_cnt;
      endcase
      case (r_estado)
        INICIAR: begin
          r_timer <= '0;
          r_count <= '0;
          r_rd    <= '0;
          r_ovf   <= 1'b0;
        end
        BUSCANDO: begin
          r_timer <= r_timer + TMR_W'(1);
          if (w_grava)   r_count <= r_count + CNT_W'(1);
          if (w_ovf_set) r_ovf   <= 1'b1;
        end
        ENVIANDO: begin
          if (w_hs) r_rd <= r_rd + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; their contents are only observed
  // through the valid-qualified pointers above.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fila_fonte[r_wr_ptr]   <= req_fonte_in;
      r_fila_destino[r_wr_ptr] <= req_destino_in;
    end
    if (w_grava) r_buf[r_count[IDX_W-1:0]] <= nucleo_dado_in;
  end

`ifdef CONTROLADOR_ESTATISTICAS_EN
  logic [15:0] r_stat_concluidos, r_stat_timeouts;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_concluidos <= '0;
      r_stat_timeouts   <= '0;
    end else begin
      if ((r_estado == ENVIANDO) & w_hs & cam_ultimo_out & (r_stat_concluidos != 16'hFFFF))
        r_stat_concluidos <= r_stat_concluidos + 16'd1;
      if (nucleo_abortar_out & (r_stat_timeouts != 16'hFFFF))
        r_stat_timeouts <= r_stat_timeouts + 16'd1;
    end
  end

  assign stat_concluidos_out = r_stat_concluidos;
  assign stat_timeouts_out   = r_stat_timeouts;
`endif

endmodule
`default_nettype wire
